// File: rtl/mips32_pkg.sv
// Shared MIPS32 constants and the program-loader state encoding.
package mips32_pkg;
  localparam int WORD_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [5:0] HLT_OPCODE = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_INIT,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_ERR
  } loader_state_e;
endpackage

// File: rtl/mips32_prog_loader_if.sv
// Program-word stream into the loader.
// Handshake: a word transfers on a clk1 edge where in_valid & in_ready are both 1;
// in_data/in_last must stay stable while in_valid is high and in_ready is low.
interface mips32_prog_loader_if;
  import mips32_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader: holds the core, fills Reg[k]=k, streams the program into
// instruction memory from address 0, then releases the core with a start pulse.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int NREGS     = NUM_REGS,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips32_prog_loader_if.slave in_if,
  input  logic                reload,
  output logic                rf_we,
  output logic [4:0]          rf_addr,
  output logic [WORD_W-1:0]   rf_wdata,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic                cpu_hold,
  output logic                cpu_start,
  output logic [ADDR_W:0]     word_count,
  output logic                done,
  output logic                err_overflow,
  output loader_state_e       dbg_state
);

  localparam logic [4:0]      LAST_REG  = 5'(NREGS - 1);
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(MAX_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_start_q, cpu_start_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              load_st;
  logic              hs;

  assign load_st = (state_q == ST_LOAD);
  assign hs      = in_if.in_valid & load_st;

  always_comb begin
    state_d      = state_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    cpu_start_d  = 1'b0;
    word_count_d = word_count_q;
    done_d       = done_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_REG_INIT;
        rf_we_d   = 1'b1;
        rf_addr_d = 5'd0;
      end
      ST_REG_INIT: begin
        // rf_addr_q is the entry being presented this cycle.
        if (rf_addr_q == LAST_REG) begin
          state_d = ST_LOAD;
        end else begin
          rf_we_d   = 1'b1;
          rf_addr_d = rf_addr_q + 5'd1;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = word_count_q[ADDR_W-1:0];
          mem_wdata_d  = in_if.in_data;
          word_count_d = word_count_q + 1'b1;
          if (in_if.in_last) begin
            state_d     = ST_START;
            cpu_start_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else if (word_count_q == LAST_WORD) begin
            // Capacity exhausted without a last marker; the word is still written.
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      ST_START: begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
      ST_RUN: begin
        if (reload) begin
          state_d      = ST_REG_INIT;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          word_count_d = '0;
          rf_we_d      = 1'b1;
          rf_addr_d    = 5'd0;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= 5'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      cpu_start_q  <= 1'b0;
      word_count_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      cpu_start_q  <= cpu_start_d;
      word_count_q <= word_count_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_if.in_ready = load_st;
  assign rf_we          = rf_we_q;
  assign rf_addr        = rf_addr_q;
  assign rf_wdata       = WORD_W'(rf_addr_q);
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign cpu_start      = cpu_start_q;
  assign word_count     = word_count_q;
  assign done           = done_q;
  assign err_overflow   = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: init-sequence table, directed load/reload/reset
// sequences, overflow on a 4-word instance, and randomized programs.
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A (default capacity) ----------------
  mips32_prog_loader_if a_if ();
  logic a_rst_n, a_reload, a_rf_we, a_mem_we, a_cpu_hold, a_cpu_start, a_done, a_err;
  logic [4:0] a_rf_addr;
  logic [31:0] a_rf_wdata, a_mem_wdata;
  logic [AW-1:0] a_mem_addr;
  logic [AW:0] a_word_count;
  loader_state_e a_state;

  mips32_prog_loader dut_a (
    .clk1(clk1), .rst_n(a_rst_n), .in_if(a_if), .reload(a_reload),
    .rf_we(a_rf_we), .rf_addr(a_rf_addr), .rf_wdata(a_rf_wdata),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .cpu_hold(a_cpu_hold), .cpu_start(a_cpu_start), .word_count(a_word_count),
    .done(a_done), .err_overflow(a_err), .dbg_state(a_state)
  );

  // ---------------- DUT B (MAX_WORDS = 4) ----------------
  mips32_prog_loader_if b_if ();
  logic b_rst_n, b_reload, b_rf_we, b_mem_we, b_cpu_hold, b_cpu_start, b_done, b_err;
  logic [4:0] b_rf_addr;
  logic [31:0] b_rf_wdata, b_mem_wdata;
  logic [AW-1:0] b_mem_addr;
  logic [AW:0] b_word_count;
  loader_state_e b_state;

  mips32_prog_loader #(.MAX_WORDS(4)) dut_b (
    .clk1(clk1), .rst_n(b_rst_n), .in_if(b_if), .reload(b_reload),
    .rf_we(b_rf_we), .rf_addr(b_rf_addr), .rf_wdata(b_rf_wdata),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .cpu_hold(b_cpu_hold), .cpu_start(b_cpu_start), .word_count(b_word_count),
    .done(b_done), .err_overflow(b_err), .dbg_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  logic [AW+31:0] got_a_q[$];
  logic [AW+31:0] got_b_q[$];
  logic [AW+31:0] exp_q[$];
  int a_starts, b_starts, a_rf_writes;
  logic [31:0] rf_seen[32];
  logic [31:0] model_regs[32];

  always @(negedge clk1) begin
    if (a_mem_we) got_a_q.push_back({a_mem_addr, a_mem_wdata});
    if (a_cpu_start) a_starts++;
    if (a_rf_we) begin
      a_rf_writes++;
      rf_seen[a_rf_addr] = a_rf_wdata;
    end
    if (b_mem_we) got_b_q.push_back({b_mem_addr, b_mem_wdata});
    if (b_cpu_start) b_starts++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_a();
    got_a_q.delete();
    a_starts = 0;
    a_rf_writes = 0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_in_ready"}, a_if.in_ready, 0);
    check({tag, "_rf_we"}, a_rf_we, 0);
    check({tag, "_rf_addr"}, a_rf_addr, 0);
    check({tag, "_rf_wdata"}, a_rf_wdata, 0);
    check({tag, "_mem_we"}, a_mem_we, 0);
    check({tag, "_mem_addr"}, a_mem_addr, 0);
    check({tag, "_mem_wdata"}, a_mem_wdata, 0);
    check({tag, "_cpu_hold"}, a_cpu_hold, 1);
    check({tag, "_cpu_start"}, a_cpu_start, 0);
    check({tag, "_word_count"}, a_word_count, 0);
    check({tag, "_done"}, a_done, 0);
    check({tag, "_err"}, a_err, 0);
  endtask

  task automatic wait_ready_a(output int n);
    n = 0;
    while (!a_if.in_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each word, 2 random 0..2 idle cycles
  task automatic send_a(input logic [31:0] w[$], input int gap_mode, input logic with_last);
    int n;
    int g;
    for (int i = 0; i < w.size(); i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      a_if.in_valid = 1'b0;
      repeat (g) tick();
      a_if.in_valid = 1'b1;
      a_if.in_data  = w[i];
      a_if.in_last  = with_last && (i == w.size() - 1);
      n = 0;
      while (!a_if.in_ready && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) begin
        check("send_ready_timeout", 1, 0);
        a_if.in_valid = 1'b0;
        return;
      end
      tick();
      a_if.in_valid = 1'b0;
      a_if.in_last  = 1'b0;
      if (with_last && i == w.size() - 1) begin
        check("last_cpu_start", a_cpu_start, 1);
        check("last_cpu_hold", a_cpu_hold, 0);
        check("last_mem_we", a_mem_we, 1);
        check("last_mem_addr", a_mem_addr, i);
      end
    end
  endtask

  task automatic check_mem_a(input logic [31:0] w[$], input string tag);
    exp_q.delete();
    for (int i = 0; i < w.size(); i++) exp_q.push_back({AW'(i), w[i]});
    check({tag, "_nwrites"}, got_a_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_a_q.size(); i++)
      check({tag, "_write"}, got_a_q[i], exp_q[i]);
  endtask

  // Reference: execute the written image on a tiny ISA model seeded from the rf writes.
  task automatic run_model();
    logic [31:0] ins;
    for (int k = 0; k < 32; k++) model_regs[k] = rf_seen[k];
    for (int pc = 0; pc < got_a_q.size(); pc++) begin
      ins = got_a_q[pc][31:0];
      if (ins[31:26] == HLT_OPCODE) break;
      case (ins[31:26])
        6'h00: model_regs[ins[15:11]] = model_regs[ins[25:21]] + model_regs[ins[20:16]];
        6'h03: model_regs[ins[15:11]] = model_regs[ins[25:21]] | model_regs[ins[20:16]];
        6'h0a: model_regs[ins[20:16]] = model_regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        default: ;
      endcase
    end
  endtask

  typedef struct {
    int         cyc;
    logic       rf_we;
    logic [4:0] rf_addr;
    logic       in_ready;
    logic       cpu_hold;
  } init_vec_t;

  init_vec_t tv[7];
  logic s_we[36];
  logic [4:0] s_addr[36];
  logic [31:0] s_wd[36];
  logic s_rdy[36];
  logic s_hold[36];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    logic [31:0] prog9[$];
    logic [31:0] w[$];
    int n;
    int len;
    int hold_low;

    prog9 = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    tv[0] = '{0, 1'b0, 5'd0, 1'b0, 1'b1};
    tv[1] = '{1, 1'b1, 5'd0, 1'b0, 1'b1};
    tv[2] = '{2, 1'b1, 5'd1, 1'b0, 1'b1};
    tv[3] = '{17, 1'b1, 5'd16, 1'b0, 1'b1};
    tv[4] = '{32, 1'b1, 5'd31, 1'b0, 1'b1};
    tv[5] = '{33, 1'b0, 5'd0, 1'b1, 1'b1};
    tv[6] = '{35, 1'b0, 5'd0, 1'b1, 1'b1};

    a_rst_n = 0; a_reload = 0; a_if.in_valid = 0; a_if.in_data = 0; a_if.in_last = 0;
    b_rst_n = 0; b_reload = 0; b_if.in_valid = 0; b_if.in_data = 0; b_if.in_last = 0;
    repeat (3) tick();
    @(negedge clk1);
    check_reset_a("por");
    tick();

    // Init sequence: cycle n is the period ending at the n-th rst_n-high edge.
    a_rst_n = 1;
    clear_a();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk1);
      s_we[c] = a_rf_we; s_addr[c] = a_rf_addr; s_wd[c] = a_rf_wdata;
      s_rdy[c] = a_if.in_ready; s_hold[c] = a_cpu_hold;
      @(posedge clk1);
      #1;
    end
    for (int i = 0; i < 7; i++) begin
      check($sformatf("init_c%0d_rf_we", tv[i].cyc), s_we[tv[i].cyc], tv[i].rf_we);
      if (tv[i].rf_we)
        check($sformatf("init_c%0d_rf_addr", tv[i].cyc), s_addr[tv[i].cyc], tv[i].rf_addr);
      check($sformatf("init_c%0d_in_ready", tv[i].cyc), s_rdy[tv[i].cyc], tv[i].in_ready);
      check($sformatf("init_c%0d_cpu_hold", tv[i].cyc), s_hold[tv[i].cyc], tv[i].cpu_hold);
    end
    hold_low = 0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("init_rf_c%0d", c), {s_we[c], 27'd0, s_addr[c], s_wd[c]},
            {1'b1, 27'd0, 5'(c - 1), 32'(c - 1)});
    end
    for (int c = 0; c < 36; c++) if (!s_hold[c]) hold_low++;
    check("init_hold_low_cycles", hold_low, 0);
    check("init_rf_writes", a_rf_writes, 32);

    // 9-word program, back-to-back
    clear_a();
    send_a(prog9, 0, 1'b1);
    repeat (3) tick();
    check_mem_a(prog9, "p9");
    check("p9_word_count", a_word_count, 9);
    check("p9_starts", a_starts, 1);
    check("p9_done", a_done, 1);
    check("p9_cpu_hold", a_cpu_hold, 0);
    run_model();
    check("p9_R1", model_regs[1], 10);
    check("p9_R2", model_regs[2], 20);
    check("p9_R3", model_regs[3], 25);
    check("p9_R4", model_regs[4], 30);
    check("p9_R5", model_regs[5], 55);

    // reload from RUN, then the same program with in_valid toggling
    a_reload = 1; tick(); a_reload = 0;
    check("rl_cpu_hold", a_cpu_hold, 1);
    check("rl_done", a_done, 0);
    check("rl_word_count", a_word_count, 0);
    check("rl_state", a_state, ST_REG_INIT);
    clear_a();
    wait_ready_a(n);
    check("rl_ready_latency", n, 32);
    check("rl_rf_writes", a_rf_writes, 32);
    send_a(prog9, 1, 1'b1);
    repeat (3) tick();
    check_mem_a(prog9, "tog");
    check("tog_starts", a_starts, 1);
    check("tog_word_count", a_word_count, 9);

    // one-cycle reset after 3 words of a fresh load
    a_reload = 1; tick(); a_reload = 0;
    wait_ready_a(n);
    clear_a();
    w = '{32'h11111111, 32'h22222222, 32'h33333333};
    send_a(w, 0, 1'b0);
    a_rst_n = 0;
    tick();
    a_rst_n = 1;
    @(negedge clk1);
    check_reset_a("mid");
    check("mid_pre_writes", got_a_q.size(), 3);
    check("mid_starts", a_starts, 0);
    clear_a();
    tick();
    wait_ready_a(n);
    check("mid_ready_latency", n, 32);
    check("mid_rf_writes", a_rf_writes, 32);
    clear_a();
    w = '{32'hcafe0001, 32'hfc000000};
    send_a(w, 0, 1'b1);
    repeat (3) tick();
    check_mem_a(w, "mid2");
    check("mid2_starts", a_starts, 1);
    check("mid2_done", a_done, 1);

    // randomized programs, each started by reload from RUN
    for (int it = 0; it < 6; it++) begin
      a_reload = 1; tick(); a_reload = 0;
      wait_ready_a(n);
      check($sformatf("rnd%0d_ready_latency", it), n, 32);
      clear_a();
      len = $urandom_range(1, 20);
      w.delete();
      for (int i = 0; i < len; i++) w.push_back($urandom);
      send_a(w, 2, 1'b1);
      repeat (3) tick();
      check_mem_a(w, $sformatf("rnd%0d", it));
      check($sformatf("rnd%0d_word_count", it), a_word_count, len);
      check($sformatf("rnd%0d_starts", it), a_starts, 1);
      check($sformatf("rnd%0d_done", it), a_done, 1);
    end

    // overflow on the 4-word instance: 5 words, no last marker
    b_rst_n = 1;
    w = '{32'ha0000000, 32'ha1111111, 32'ha2222222, 32'ha3333333, 32'ha4444444};
    begin
      int accepted;
      accepted = 0;
      for (int i = 0; i < 5; i++) begin
        b_if.in_valid = 1'b1;
        b_if.in_data  = w[i];
        b_if.in_last  = 1'b0;
        n = 0;
        while (!b_if.in_ready && n < 40) begin
          tick();
          n++;
        end
        if (b_if.in_ready) begin
          tick();
          accepted++;
        end
      end
      b_if.in_valid = 1'b0;
      check("ovf_accepted", accepted, 4);
    end
    repeat (2) tick();
    check("ovf_nwrites", got_b_q.size(), 4);
    for (int i = 0; i < 4 && i < got_b_q.size(); i++)
      check($sformatf("ovf_write%0d", i), got_b_q[i], {AW'(i), w[i]});
    check("ovf_err", b_err, 1);
    check("ovf_state", b_state, ST_ERR);
    check("ovf_cpu_hold", b_cpu_hold, 1);
    check("ovf_starts", b_starts, 0);
    check("ovf_word_count", b_word_count, 4);
    check("ovf_in_ready", b_if.in_ready, 0);
    b_reload = 1; tick(); b_reload = 0;
    repeat (2) tick();
    check("ovf_reload_state", b_state, ST_ERR);
    check("ovf_reload_err", b_err, 1);
    check("ovf_reload_done", b_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Boot-time loader that sits directly upstream of the pipelined MIPS32 core. Holds the core halted, initialises the register file to Reg[k]=k, then streams program words into instruction memory starting at address 0. On the final word it releases the core with a one-cycle start pulse that clears PC, HALTED and TAKEN_BRANCH. This replaces hierarchical pokes into the core's Mem/Reg arrays with a real write path.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- NREGS, 32, register-file entries initialised
- MAX_WORDS, 1024, program capacity in words (≤ 2**ADDR_W)

- clk1  in  1  single loader clock, same net as core clk1
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  program word offered
- in_ready  out  1  loader accepts word this cycle
- in_data  in  32  program word
- in_last  in  1  marks final word of program
- reload  in  1  pulse in RUN: restart full load sequence
- rf_we  out  1  register-file write strobe
- rf_addr  out  5  register index
- rf_wdata  out  32  register init value
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  keeps core halted (HALTED forced 1)
- cpu_start  out  1  one-cycle pulse: PC←0, HALTED←0, TAKEN_BRANCH←0
- word_count  out  ADDR_W+1  words written this load
- done  out  1  program loaded, core running
- err_overflow  out  1  sticky, program exceeded MAX_WORDS

## Operation
- States: IDLE, REG_INIT, LOAD, START, RUN, ERR.
- IDLE: one cycle after reset release; → REG_INIT.
- REG_INIT: rf_we=1, rf_addr=k, rf_wdata=k for k=0..NREGS-1, one entry per cycle; after k=NREGS-1 → LOAD.
- LOAD: in_ready=1. Handshake = in_valid & in_ready. Each handshake writes in_data to address word_count, word_count increments.
  - Handshake with in_last=1 → START.
  - Handshake at word_count=MAX_WORDS-1 with in_last=0 → ERR (that word is still written).
  - in_valid low: no write, state held; no timeout.
- START: cpu_start=1 for exactly one cycle, cpu_hold drops to 0 in the same cycle; → RUN.
- RUN: done=1, in_ready=0, in_data ignored. reload=1 → REG_INIT with cpu_hold=1, done=0, word_count=0 the next cycle.
- ERR: cpu_hold=1, err_overflow=1, in_ready=0; exits only through reset. reload ignored.
- Reset (any state, including mid-REG_INIT or mid-LOAD) aborts immediately; partially written memory is not cleared.

## Timing
- Reset values: in_ready=0, rf_we=0, rf_addr=0, rf_wdata=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, word_count=0, done=0, err_overflow=0.
- All outputs registered; in_ready is a decode of the registered state.
- Write latency: handshake at edge N → mem_we/mem_addr/mem_wdata valid during cycle N+1 (written by the core's memory on edge N+1).
- First rst_n-high edge = cycle 0 (IDLE). REG_INIT occupies cycles 1..NREGS. in_ready first high in cycle NREGS+1.
- Last-word handshake at edge M → cpu_start high in cycle M+1, which is also the cycle the last mem_we is presented; core begins fetching from cycle M+2.
- Back-to-back handshakes sustain one word per cycle.

## Structure
- Shared package mips32_pkg: WORD_W=32, NREGS, HLT opcode constant 6'h3f, loader state enum.
- Single flat module. No sub-module is required; counter and FSM are small enough to live together.

## Test plan
- Reset then idle stream: check rf writes 0..31 with rf_wdata=rf_addr in cycles 1..32, cpu_hold=1 throughout, in_ready=1 from cycle 33.
- Stream 9 words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last on the 9th) → mem writes to addresses 0..8, word_count=9, single cpu_start pulse, done=1. With the core attached, R1=10, R2=20, R3=25, R4=30, R5=55.
- Same stream with in_valid toggling every other cycle → identical memory contents, no duplicate or missing writes.
- MAX_WORDS=4, stream 5 words without last → addresses 0..3 written, ERR entered, err_overflow=1, cpu_start never pulses, 5th word not accepted.
- rst_n low for one cycle mid-LOAD after 3 words → all outputs at reset values, full sequence restarts from REG_INIT.
- reload in RUN → cpu_hold=1 and done=0 next cycle, REG_INIT repeats, a new 2-word load ends with one cpu_start.
